// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel scheduler: channel count,
// quota width, scheduler states and the channel-index type.
package dma_pkg;

  localparam int NCH     = 4;
  localparam int QUOTA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RELEASE
  } state_e;

  typedef logic [1:0] ch_idx_t;

  // Convert a one-hot channel vector into its binary index (zero if empty).
  function automatic ch_idx_t onehot_to_idx(input logic [NCH-1:0] oh);
    ch_idx_t idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oh[i]) begin
        idx = ch_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: searches the eligible vector starting
// one position after ptr_i, wrapping around, and returns a one-hot winner.
module dma_rr_pick
  import dma_pkg::*;
(
  input  logic [NCH-1:0] eligible_i,
  input  ch_idx_t        ptr_i,
  output logic [NCH-1:0] winner_o,
  output logic           valid_o
);

  ch_idx_t idx;

  // Walk ptr+1, ptr+2, ... ptr+NCH; the 2-bit index wraps naturally because NCH is 4.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = ptr_i + ch_idx_t'(k);
      if (!valid_o && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_ch_sched.sv
// Round-robin tenure scheduler sharing the single AHB master port among the
// DMA channels. Grants one eligible channel per tenure, counts its data
// beats against the programmed quota and acks the peripheral at tenure end.
module dma_ch_sched #(
  parameter int NCH     = dma_pkg::NCH,
  parameter int QUOTA_W = dma_pkg::QUOTA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH-1:0]         fifo_full,
  input  logic [NCH*QUOTA_W-1:0] quota,
  input  logic                   beat_done,
  input  logic                   ch_last,
  output logic [NCH-1:0]         grant,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic [NCH-1:0]         ack
);

  import dma_pkg::*;

  state_e               state_q;
  logic [NCH-1:0]       grant_q;
  logic [NCH-1:0]       ack_q;
  ch_idx_t              grantId_q;
  ch_idx_t              ptr_q;
  logic                 busy_q;
  logic [QUOTA_W-1:0]   beatCnt_q;

  logic [NCH-1:0]       eligible;
  logic [NCH-1:0]       winnerOh;
  logic                 winnerValid;
  logic [QUOTA_W-1:0]   quotaG;
  logic                 tenureEnd;

  assign eligible = req & ch_en & ~fifo_full;

  dma_rr_pick uPick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (winnerOh),
    .valid_o    (winnerValid)
  );

  // Tenure end: abort on channel disable, or a beat that hits quota, last or FIFO full.
  always_comb begin
    quotaG    = quota[grantId_q*QUOTA_W +: QUOTA_W];
    tenureEnd = ~ch_en[grantId_q]
              | (beat_done & ((beatCnt_q == quotaG) | ch_last | fifo_full[grantId_q]));
  end

  // Scheduler FSM with registered grant/busy/ack, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      grantId_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      beatCnt_q <= '0;
      ptr_q     <= ch_idx_t'(NCH-1);
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (winnerValid) begin
            grant_q   <= winnerOh;
            grantId_q <= onehot_to_idx(winnerOh);
            busy_q    <= 1'b1;
            beatCnt_q <= '0;
            state_q   <= XFER;
          end
        end
        XFER: begin
          if (tenureEnd) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= grant_q;
            ptr_q   <= grantId_q;
            state_q <= RELEASE;
          end else if (beat_done) begin
            beatCnt_q <= beatCnt_q + QUOTA_W'(1);
          end
        end
        RELEASE: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grantId_q;
  assign busy     = busy_q;
  assign ack      = ack_q;

endmodule
